// File: rtl/fifo_rd_framer_if.sv
// FIFO read port plus the outgoing valid/ready stream of the read-side framer.
// The master side is the framer; the slave side is the FIFO and downstream sink.
interface fifo_rd_framer_if #(
    parameter int WIDTH = 16
);
    logic             r_en;
    logic             empty;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;

    modport master (
        output r_en, m_data, m_valid, m_last,
        input  empty, rd_data, m_ready
    );

    modport slave (
        input  r_en, m_data, m_valid, m_last,
        output empty, rd_data, m_ready
    );
endinterface

// File: rtl/fifo_rd_framer.sv
// Drains the dual-clock FIFO read port into a framed valid/ready stream,
// absorbing the RAM's one-cycle read latency with a 2-entry output buffer.
module fifo_rd_framer #(
    parameter int WIDTH     = 16,
    parameter int FRAME_LEN = 8
) (
    input  logic                   r_clk,
    input  logic                   r_rst,
    input  logic                   en,
    fifo_rd_framer_if.master       bus,
    output logic [15:0]            frame_cnt,
    output logic                   busy
);
    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state_q, state_d;
    logic [1:0]       occ_q, occ_d;
    logic             inflight_q, inflight_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [WIDTH-1:0] buf_q [2];
    logic [WIDTH-1:0] buf_d [2];

    logic             m_valid;
    logic             m_last;
    logic             pop;
    logic             rd_go;
    logic [1:0]       occ_kept;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
    endfunction

    always_comb begin
        m_valid = (occ_q != 2'd0);
        m_last  = m_valid && (out_idx_q == LAST_IDX);
        pop     = m_valid && bus.m_ready;
        // Words already owned (buffered or in flight) must leave a free slot
        // for the word this read returns next cycle.
        rd_go   = ((state_q == RUN) || (state_q == FINISH)) && !bus.empty &&
                  (({1'b0, occ_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop})) &&
                  !r_rst;

        buf_d[0] = buf_q[0];
        buf_d[1] = buf_q[1];
        if (pop) begin
            buf_d[0] = buf_q[1];
        end
        occ_kept = occ_q - {1'b0, pop};
        if (inflight_q) begin
            buf_d[occ_kept[0]] = bus.rd_data;
        end
        occ_d = occ_kept + {1'b0, inflight_q};

        inflight_d  = rd_go;
        rd_idx_d    = rd_go ? idx_inc(rd_idx_q) : rd_idx_q;
        out_idx_d   = pop ? idx_inc(out_idx_q) : out_idx_q;
        frame_cnt_d = (pop && m_last) ? frame_cnt_q + 16'd1 : frame_cnt_q;

        // Stopping is deferred to a frame boundary so that a stopped block
        // has always read whole frames.
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = (rd_idx_d == '0) ? IDLE : FINISH;
            FINISH:  if (rd_go && (rd_idx_q == LAST_IDX)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state_q     <= IDLE;
            occ_q       <= 2'd0;
            inflight_q  <= 1'b0;
            rd_idx_q    <= '0;
            out_idx_q   <= '0;
            frame_cnt_q <= 16'd0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            inflight_q  <= inflight_d;
            rd_idx_q    <= rd_idx_d;
            out_idx_q   <= out_idx_d;
            frame_cnt_q <= frame_cnt_d;
            buf_q[0]    <= buf_d[0];
            buf_q[1]    <= buf_d[1];
        end
    end

    assign bus.r_en    = rd_go;
    assign bus.m_data  = buf_q[0];
    assign bus.m_valid = m_valid;
    assign bus.m_last  = m_last;
    assign frame_cnt   = frame_cnt_q;
    assign busy        = (state_q != IDLE) || inflight_q || (occ_q != 2'd0);
endmodule

// File: tb/tb_fifo_rd_framer.sv
// Bench for fifo_rd_framer: a FIFO model feeds it, a word-order scoreboard
// checks the stream every cycle, and directed scenarios pin literal results.
module tb_fifo_rd_framer;
    localparam int W  = 16;
    localparam int FL = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        r_rst = 1'b1;
    logic        en = 1'b0;
    logic        force_empty = 1'b0;
    logic        rdy = 1'b1;
    logic        bp_mode = 1'b0;
    logic [15:0] rd_q = 16'd0;
    logic [15:0] frame_cnt;
    logic        busy;

    fifo_rd_framer_if #(.WIDTH(W)) bus ();

    fifo_rd_framer #(.WIDTH(W), .FRAME_LEN(FL)) dut (
        .r_clk    (clk),
        .r_rst    (r_rst),
        .en       (en),
        .bus      (bus),
        .frame_cnt(frame_cnt),
        .busy     (busy)
    );

    // FIFO model: registered read data, one-cycle latency
    logic [15:0] mem [256];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    assign bus.empty   = force_empty || (rd_ptr == wr_ptr);
    assign bus.rd_data = rd_q;
    assign bus.m_ready = rdy;

    always @(posedge clk) begin
        if (bus.r_en && !bus.empty) begin
            rd_q   <= mem[rd_ptr[7:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every word read must leave in order, m_last on every
    // FL-th word since reset, at most two words owned by the block.
    logic [15:0] expq [$];
    logic [15:0] lastw [$];
    int          outstanding = 0;
    int          out_count = 0;
    int          exp_frames = 0;
    int          cyc = 0;
    int          reads_total = 0;
    int          pops_total = 0;
    int          acc_cyc [512];
    int          pop_cyc [512];
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = 16'd0;
    logic        prev_last = 1'b0;
    logic        just_reset = 1'b0;

    always @(negedge clk) begin
        logic        acc;
        logic        pop;
        logic        exp_last;
        logic [15:0] e;
        cyc++;
        if (r_rst) begin
            chk("r_en_in_reset", 32'(bus.r_en), 32'd0);
            if (just_reset) begin
                chk("rst_valid", 32'(bus.m_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
            end
            expq.delete();
            outstanding = 0;
            out_count   = 0;
            exp_frames  = 0;
            prev_stall  = 1'b0;
            just_reset  = 1'b1;
        end else begin
            if (just_reset) begin
                chk("post_rst_valid", 32'(bus.m_valid), 32'd0);
                chk("post_rst_last", 32'(bus.m_last), 32'd0);
                chk("post_rst_data", 32'(bus.m_data), 32'd0);
                chk("post_rst_busy", 32'(busy), 32'd0);
                chk("post_rst_frame_cnt", 32'(frame_cnt), 32'd0);
                just_reset = 1'b0;
            end
            acc      = bus.r_en && !bus.empty;
            pop      = bus.m_valid && bus.m_ready;
            exp_last = ((out_count % FL) == FL - 1);
            chk("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
            if (bus.r_en) chk("space", 32'((outstanding - int'(pop)) < 2), 32'd1);
            if (outstanding > 0) chk("busy", 32'(busy), 32'd1);
            if (prev_stall) begin
                chk("hold_valid", 32'(bus.m_valid), 32'd1);
                chk("hold_data", 32'(bus.m_data), 32'(prev_data));
                chk("hold_last", 32'(bus.m_last), 32'(prev_last));
            end
            if (bus.m_valid) begin
                chk("valid_has_word", 32'(expq.size() > 0), 32'd1);
                chk("m_last", 32'(bus.m_last), 32'(exp_last));
            end else begin
                chk("m_last_idle", 32'(bus.m_last), 32'd0);
            end
            if (pop && expq.size() > 0) begin
                e = expq.pop_front();
                chk("m_data", 32'(bus.m_data), 32'(e));
                if (exp_last) begin
                    lastw.push_back(bus.m_data);
                    exp_frames++;
                end
                out_count++;
                outstanding--;
                pop_cyc[pops_total % 512] = cyc;
                pops_total++;
            end
            if (acc) begin
                expq.push_back(mem[rd_ptr[7:0]]);
                outstanding++;
                acc_cyc[reads_total % 512] = cyc;
                reads_total++;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
        end
    end

    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int   pk = 0;

    task automatic step();
        @(posedge clk);
        #1;
        if (bp_mode) begin
            rdy = pat[pk % 6];
            pk++;
        end
    endtask

    task automatic load(input int n, input logic [15:0] first);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[7:0]] = first + 16'(i);
            wr_ptr++;
        end
    endtask

    task automatic wait_pops(input int target, input int budget);
        int n = 0;
        while (pops_total < target && n < budget) begin
            step();
            n++;
        end
        chk("wait_pops", 32'(pops_total >= target), 32'd1);
    endtask

    task automatic wait_reads(input int target, input int budget);
        int n = 0;
        while (reads_total < target && n < budget) begin
            step();
            n++;
        end
        chk("wait_reads", 32'(reads_total >= target), 32'd1);
    endtask

    initial begin
        // Reset held 3 cycles with en=1 and data available
        load(16, 16'h0001);
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1 r_rst = 1'b0;
        @(negedge clk);
        chk("first_r_en_c1", 32'(bus.r_en), 32'd0);
        @(negedge clk);
        chk("first_r_en_c2", 32'(bus.r_en), 32'd1);

        // Streaming
        wait_pops(16, 200);
        chk("stream_reads", 32'(reads_total), 32'd16);
        chk("stream_acc_run", 32'(acc_cyc[15] - acc_cyc[0]), 32'd15);
        chk("stream_latency", 32'(pop_cyc[0] - acc_cyc[0]), 32'd2);
        chk("stream_vld_run", 32'(pop_cyc[15] - pop_cyc[0]), 32'd15);
        chk("stream_frames", 32'(frame_cnt), 32'd2);
        chk("stream_last0", 32'(lastw[0]), 32'h0008);
        chk("stream_last1", 32'(lastw[1]), 32'h0010);
        en = 1'b0;
        repeat (3) step();

        // Backpressure
        load(16, 16'h0001);
        en = 1'b1;
        bp_mode = 1'b1;
        wait_pops(32, 400);
        bp_mode = 1'b0;
        rdy = 1'b1;
        en = 1'b0;
        chk("bp_frames", 32'(frame_cnt), 32'd4);
        chk("bp_last0", 32'(lastw[2]), 32'h0008);
        chk("bp_last1", 32'(lastw[3]), 32'h0010);
        repeat (3) step();

        // Stop mid-frame
        load(20, 16'h0101);
        en = 1'b1;
        wait_reads(35, 100);
        en = 1'b0;
        wait_pops(40, 200);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_reads", 32'(reads_total), 32'd40);
        chk("stop_left", 32'(wr_ptr - rd_ptr), 32'd12);
        chk("stop_frames", 32'(frame_cnt), 32'd5);
        chk("stop_last", 32'(lastw[4]), 32'h0108);
        repeat (5) step();
        chk("stop_no_more", 32'(reads_total), 32'd40);

        // Empty mid-frame
        load(4, 16'h0115);
        en = 1'b1;
        wait_reads(44, 100);
        force_empty = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("empty_r_en", 32'(bus.r_en), 32'd0);
            if (i == 4) chk("empty_drained", 32'(bus.m_valid), 32'd0);
        end
        @(posedge clk);
        #1 force_empty = 1'b0;
        wait_pops(56, 200);
        en = 1'b0;
        chk("empty_frames", 32'(frame_cnt), 32'd7);
        chk("empty_last0", 32'(lastw[5]), 32'h0110);
        chk("empty_last1", 32'(lastw[6]), 32'h0118);
        repeat (3) step();

        // Reset mid-operation with a stalled, full buffer
        load(16, 16'h0201);
        rdy = 1'b0;
        en = 1'b1;
        wait_reads(58, 50);
        repeat (2) step();
        chk("mid_owned", 32'(outstanding), 32'd2);
        r_rst = 1'b1;
        step();
        r_rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(bus.m_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_frames", 32'(frame_cnt), 32'd0);
        rdy = 1'b1;
        wait_pops(64, 200);
        chk("mid_rst_last", 32'(lastw[7]), 32'h020A);
        chk("mid_rst_frames2", 32'(frame_cnt), 32'd1);
        en = 1'b0;
        repeat (12) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
